// File: rtl/lc3_pkg.sv
// Shared LC3 pipeline types and constants.
package lc3_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

    localparam word_t       LC3_BASE_ADDR    = 16'h3000;
    localparam int unsigned LC3_STALL_THRESH = 1000;

endpackage

// File: rtl/lc3_stall_watchdog.sv
// Saturating stall counter with a sticky timeout flag; shared by memory-facing stages.
module lc3_stall_watchdog
    import lc3_pkg::*;
#(
    parameter int unsigned THRESH = LC3_STALL_THRESH
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_active,
    input  logic i_done,
    output logic o_timeout
);

    localparam int unsigned CNT_W = $clog2(THRESH + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_timeout;

    // Count waiting cycles, clear on completion or when idle, saturate at the threshold.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!i_active || i_done) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != CNT_W'(THRESH)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Counter register and sticky timeout, cleared only by reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == CNT_W'(THRESH)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC3 fetch stage: owns the PC, runs the instruction-memory handshake, squashes redirected fetches.
module lc3_fetch_unit
    import lc3_pkg::*;
#(
    parameter word_t       BASE_ADDR    = LC3_BASE_ADDR,
    parameter int unsigned STALL_THRESH = LC3_STALL_THRESH
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable_fetch,
    input  logic        enable_updatePC,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    input  logic [15:0] Instr_dout,
    input  logic        complete_instr,
    output logic [15:0] pc,
    output logic [15:0] npc_out,
    output logic        instrmem_rd,
    output logic [15:0] ir_out,
    output logic        ir_valid,
    output logic        fetch_busy,
    output logic        timeout_err
);

    fetch_state_e r_state;
    word_t        r_pc;
    word_t        r_ir;
    word_t        r_tgt;
    logic         r_rd;
    logic         r_irv;
    logic         r_pend;

    fetch_state_e w_state_nxt;
    word_t        w_pc_nxt;
    word_t        w_ir_nxt;
    word_t        w_tgt_nxt;
    logic         w_rd_nxt;
    logic         w_irv_nxt;
    logic         w_pend_nxt;
    logic         w_busy;

    // Next-state, PC and IR selection for the request/accept handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_tgt_nxt   = r_tgt;
        w_rd_nxt    = r_rd;
        w_irv_nxt   = 1'b0;
        w_pend_nxt  = r_pend;
        case (r_state)
            IDLE: begin
                if (br_taken) begin
                    w_pc_nxt = taddr;
                end
                if (enable_fetch) begin
                    w_rd_nxt    = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (complete_instr) begin
                    // A redirect arriving with the data takes precedence over a pending one.
                    if (br_taken) begin
                        w_pc_nxt = taddr;
                    end else if (r_pend) begin
                        w_pc_nxt = r_tgt;
                    end else begin
                        w_ir_nxt  = Instr_dout;
                        w_irv_nxt = 1'b1;
                        if (enable_updatePC) begin
                            w_pc_nxt = r_pc + 16'd1;
                        end
                    end
                    w_pend_nxt  = 1'b0;
                    w_rd_nxt    = enable_fetch;
                    w_state_nxt = enable_fetch ? REQ : IDLE;
                end else if (br_taken) begin
                    w_pend_nxt = 1'b1;
                    w_tgt_nxt  = taddr;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_rd_nxt    = 1'b0;
            end
        endcase
    end

    // State, PC, IR and redirect registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_pc    <= BASE_ADDR;
            r_ir    <= 16'h0000;
            r_tgt   <= 16'h0000;
            r_rd    <= 1'b0;
            r_irv   <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_tgt   <= w_tgt_nxt;
            r_rd    <= w_rd_nxt;
            r_irv   <= w_irv_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    assign w_busy = (r_state == REQ);

    lc3_stall_watchdog #(
        .THRESH (STALL_THRESH)
    ) u_watchdog (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_active  (w_busy),
        .i_done    (complete_instr),
        .o_timeout (timeout_err)
    );

    assign pc          = r_pc;
    assign npc_out     = r_pc + 16'd1;
    assign instrmem_rd = r_rd;
    assign ir_out      = r_ir;
    assign ir_valid    = r_irv;
    assign fetch_busy  = w_busy;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Directed bench for lc3_fetch_unit.
module tb_lc3_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        enable_fetch;
    logic        enable_updatePC;
    logic        br_taken;
    logic [15:0] taddr;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic [15:0] pc;
    logic [15:0] npc_out;
    logic        instrmem_rd;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        fetch_busy;
    logic        timeout_err;

    int tests_run = 0;
    int tests_failed = 0;

    lc3_fetch_unit dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable_fetch    (enable_fetch),
        .enable_updatePC (enable_updatePC),
        .br_taken        (br_taken),
        .taddr           (taddr),
        .Instr_dout      (Instr_dout),
        .complete_instr  (complete_instr),
        .pc              (pc),
        .npc_out         (npc_out),
        .instrmem_rd     (instrmem_rd),
        .ir_out          (ir_out),
        .ir_valid        (ir_valid),
        .fetch_busy      (fetch_busy),
        .timeout_err     (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},   pc,          16'h3000);
        chk({tag, "_npc"},  npc_out,     16'h3001);
        chk({tag, "_rd"},   instrmem_rd, 1'b0);
        chk({tag, "_ir"},   ir_out,      16'h0000);
        chk({tag, "_irv"},  ir_valid,    1'b0);
        chk({tag, "_busy"}, fetch_busy,  1'b0);
        chk({tag, "_to"},   timeout_err, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; enable_fetch = 1'b0; enable_updatePC = 1'b1; br_taken = 1'b0;
        taddr = 16'h0000; Instr_dout = 16'h0000; complete_instr = 1'b0;
        tick(); tick();
        chk_reset("reset");
        reset_n = 1'b1;

        // Zero-latency memory, back-to-back fetches
        enable_fetch = 1'b1; complete_instr = 1'b1; Instr_dout = 16'h1111;
        tick();
        chk("z_launch_pc", pc, 16'h3000);
        chk("z_launch_rd", instrmem_rd, 1'b1);
        chk("z_launch_irv", ir_valid, 1'b0);
        tick();
        chk("z_pc1", pc, 16'h3001);
        chk("z_irv1", ir_valid, 1'b1);
        chk("z_ir1", ir_out, 16'h1111);
        Instr_dout = 16'h2222;
        tick();
        chk("z_pc2", pc, 16'h3002);
        chk("z_irv2", ir_valid, 1'b1);
        chk("z_ir2", ir_out, 16'h2222);
        enable_fetch = 1'b0; Instr_dout = 16'h3333;
        tick();
        chk("z_stop_pc", pc, 16'h3003);
        chk("z_stop_rd", instrmem_rd, 1'b0);
        chk("z_stop_ir", ir_out, 16'h3333);
        complete_instr = 1'b0;
        tick();
        chk("idle_irv", ir_valid, 1'b0);
        chk("idle_busy", fetch_busy, 1'b0);
        chk("idle_ir_hold", ir_out, 16'h3333);

        // Latency 3: redirect in IDLE to 3000, then launch
        br_taken = 1'b1; taddr = 16'h3000; enable_fetch = 1'b1;
        tick();
        br_taken = 1'b0; enable_fetch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("l3_rd_c%0d", i), instrmem_rd, 1'b1);
            chk($sformatf("l3_pc_c%0d", i), pc, 16'h3000);
            chk($sformatf("l3_irv_c%0d", i), ir_valid, 1'b0);
            if (i == 3) begin
                complete_instr = 1'b1; Instr_dout = 16'h1261;
            end
            tick();
        end
        complete_instr = 1'b0;
        chk("l3_irv", ir_valid, 1'b1);
        chk("l3_ir", ir_out, 16'h1261);
        chk("l3_pc", pc, 16'h3001);
        chk("l3_rd_drop", instrmem_rd, 1'b0);
        tick();
        chk("l3_pulse_end", ir_valid, 1'b0);

        // Accept without enable_updatePC keeps pc
        enable_updatePC = 1'b0; enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0; complete_instr = 1'b1; Instr_dout = 16'h4444;
        tick();
        complete_instr = 1'b0; enable_updatePC = 1'b1;
        chk("noupd_pc", pc, 16'h3001);
        chk("noupd_ir", ir_out, 16'h4444);

        // Redirect during the second wait cycle of fetch at 3005
        br_taken = 1'b1; taddr = 16'h3005; enable_fetch = 1'b1;
        tick();
        br_taken = 1'b0;
        chk("rd_pc_issue", pc, 16'h3005);
        tick();
        br_taken = 1'b1; taddr = 16'h3040;
        tick();
        br_taken = 1'b0;
        chk("rd_pc_stable", pc, 16'h3005);
        tick();
        complete_instr = 1'b1; Instr_dout = 16'hDEAD;
        tick();
        chk("rd_squash_irv", ir_valid, 1'b0);
        chk("rd_squash_ir", ir_out, 16'h4444);
        chk("rd_new_pc", pc, 16'h3040);
        chk("rd_new_rd", instrmem_rd, 1'b1);
        Instr_dout = 16'hABCD;
        tick();
        chk("rd_next_irv", ir_valid, 1'b1);
        chk("rd_next_ir", ir_out, 16'hABCD);
        chk("rd_next_pc", pc, 16'h3041);

        // br_taken together with complete_instr
        br_taken = 1'b1; taddr = 16'h5000; Instr_dout = 16'hBBBB;
        tick();
        chk("same_irv", ir_valid, 1'b0);
        chk("same_ir", ir_out, 16'hABCD);
        chk("same_pc", pc, 16'h5000);

        // PC wrap at FFFF
        taddr = 16'hFFFF;
        tick();
        br_taken = 1'b0;
        chk("wrap_pc_ffff", pc, 16'hFFFF);
        chk("wrap_npc_ffff", npc_out, 16'h0000);
        Instr_dout = 16'hCCCC;
        tick();
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_npc", npc_out, 16'h0001);
        chk("wrap_ir", ir_out, 16'hCCCC);

        // Memory never completes: request at 0000 outstanding
        complete_instr = 1'b0; enable_fetch = 1'b0;
        for (int i = 0; i < 999; i++) tick();
        chk("to_before", timeout_err, 1'b0);
        tick();
        chk("to_at_thresh", timeout_err, 1'b1);
        chk("to_rd_held", instrmem_rd, 1'b1);
        chk("to_busy", fetch_busy, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("to_sticky", timeout_err, 1'b1);
        complete_instr = 1'b1; enable_fetch = 1'b1; Instr_dout = 16'h7777;
        tick();
        chk("to_after_accept", timeout_err, 1'b1);
        chk("to_accept_pc", pc, 16'h0001);

        // Mid-request reset with late completions
        reset_n = 1'b0;
        tick();
        chk_reset("rst2");
        reset_n = 1'b1; enable_fetch = 1'b0;
        tick();
        chk("late_rd", instrmem_rd, 1'b0);
        chk("late_irv", ir_valid, 1'b0);
        chk("late_pc", pc, 16'h3000);
        chk("late_to", timeout_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
